// File: rtl/dmem_lsu_pkg.sv
// Shared types and helpers for the data-memory load/store initiator.
//   size_e   : access size encoding (byte/half/word/dword)
//   state_e  : initiator FSM states
//   SIM_*    : simulation-environment device addresses (passed through untouched)
//   size_base / split_access / beat0_wen / beat1_wen : lane-mask helpers
package dmem_lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT2 = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    localparam logic [63:0] SIM_PUTCHAR_ADDR = 64'h40;
    localparam logic [63:0] SIM_HALT_ADDR    = 64'h50;
    localparam logic [63:0] SIM_CYCLE_ADDR   = 64'h60;

    // (1 << n) - 1 for n = 1 << size bytes.
    function automatic logic [7:0] size_base(input logic [1:0] size);
        logic [7:0] m;
        case (size)
            2'd0:    m = 8'h01;
            2'd1:    m = 8'h03;
            2'd2:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    // An access crosses into the next 8-byte word when off + n > 8.
    function automatic logic split_access(input logic [1:0] size, input logic [2:0] off);
        return ({1'b0, off} + (4'd1 << size)) > 4'd8;
    endfunction

    function automatic logic [7:0] beat0_wen(input logic [1:0] size, input logic [2:0] off);
        return size_base(size) << off;
    endfunction

    // Shift by 8 (off = 0) yields zero, which is harmless since such an
    // access is never split.
    function automatic logic [7:0] beat1_wen(input logic [1:0] size, input logic [2:0] off);
        return size_base(size) >> (4'd8 - {1'b0, off});
    endfunction

endpackage

// File: rtl/dmem_lsu_initiator_load_align.sv
// Combinational load-data alignment: right-shifts the {high, low} 128-bit
// window by the byte offset, keeps the access size and sign/zero extends.
//   high, low   : upper / lower memory words
//   off         : byte offset of the access within the low word
//   size        : access size (size_e encoding)
//   is_unsigned : 1 = zero-extend, 0 = sign-extend
//   rdata       : extended, right-justified load data
module dmem_lsu_load_align
    import dmem_lsu_pkg::*;
(
    input  logic [63:0] high,
    input  logic [63:0] low,
    input  logic [2:0]  off,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [63:0] rdata
);

    logic [63:0] shifted;

    // Only the bottom 64 bits of the shifted window can ever be selected.
    assign shifted = 64'({high, low} >> {off, 3'b000});

    always_comb begin
        rdata = shifted;
        case (size_e'(size))
            SZ_B: rdata = is_unsigned ? {56'd0, shifted[7:0]}
                                      : {{56{shifted[7]}}, shifted[7:0]};
            SZ_H: rdata = is_unsigned ? {48'd0, shifted[15:0]}
                                      : {{48{shifted[15]}}, shifted[15:0]};
            SZ_W: rdata = is_unsigned ? {32'd0, shifted[31:0]}
                                      : {{32{shifted[31]}}, shifted[31:0]};
            default: rdata = shifted;
        endcase
    end

endmodule

// File: rtl/dmem_lsu_initiator.sv
// Load/store initiator between a core request port and a 64-bit byte-enabled
// memory port. Misaligned accesses that cross an 8-byte boundary are split
// into two memory beats; loads are realigned and extended on the response.
//
// Handshake: a request transfers on a posedge where i_req_valid & o_req_ready;
// request fields are only sampled on that edge. Every accepted request yields
// exactly one o_rsp_valid pulse (1 cycle later single-beat, 2 cycles split),
// with o_rsp_rdata = 0 for stores. Memory read data returns the cycle after
// the address edge.
//
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   i_req_* / o_req_ready    : core request channel
//   o_rsp_valid, o_rsp_rdata : completion pulse and load data
//   o_mem_addr/wdata/wen     : memory write/address port (8-byte aligned)
//   i_mem_rdata              : memory read data
//   o_dbg_state              : current FSM state
module dmem_lsu_initiator
    import dmem_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [1:0]            i_req_size,
    input  logic                  i_req_unsigned,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    output logic                  o_rsp_valid,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    output logic [7:0]            o_mem_wen,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output state_e                o_dbg_state
);

    state_e state_q, state_d;

    logic                  req_ready;
    logic                  accept;
    logic [2:0]            req_off;
    logic [ADDR_WIDTH-1:0] req_addr_aligned;

    // Request captured at accept; drives beat1 and the response.
    logic                  r_we;
    logic                  r_uns;
    logic                  r_split;
    logic [1:0]            r_size;
    logic [2:0]            r_off;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [63:0]           r_wdata;
    logic [63:0]           low_q;

    logic [63:0]           align_low;
    logic [63:0]           align_out;

    assign req_off          = i_req_addr[2:0];
    assign req_addr_aligned = {i_req_addr[ADDR_WIDTH-1:3], 3'b000};
    assign req_ready        = !rst && (state_q != ST_BEAT2);
    assign accept           = i_req_valid && req_ready;
    assign o_req_ready      = req_ready;
    assign o_dbg_state      = state_q;

    // Split loads take the low half from the beat0 capture; single-beat
    // loads find all their bytes in the current read word.
    assign align_low = r_split ? low_q : i_mem_rdata;

    dmem_lsu_load_align u_align (
        .high        (i_mem_rdata),
        .low         (align_low),
        .off         (r_off),
        .size        (r_size),
        .is_unsigned (r_uns),
        .rdata       (align_out)
    );

    always_comb begin
        state_d     = state_q;
        o_mem_addr  = req_addr_aligned;
        o_mem_wdata = i_req_wdata << {req_off, 3'b000};
        o_mem_wen   = 8'h00;
        o_rsp_valid = 1'b0;
        o_rsp_rdata = '0;

        case (state_q)
            ST_BEAT2: begin
                o_mem_addr  = r_addr + ADDR_WIDTH'(8);
                o_mem_wdata = r_wdata >> {4'd8 - {1'b0, r_off}, 3'b000};
                o_mem_wen   = r_we ? beat1_wen(r_size, r_off) : 8'h00;
                state_d     = ST_RESP;
            end
            default: begin
                // IDLE and RESP: the memory port follows the incoming request.
                if (i_req_valid && i_req_we) begin
                    o_mem_wen = beat0_wen(i_req_size, req_off);
                end
                if (state_q == ST_RESP) begin
                    o_rsp_valid = 1'b1;
                    if (!r_we) begin
                        o_rsp_rdata = align_out;
                    end
                end
                if (accept) begin
                    state_d = split_access(i_req_size, req_off) ? ST_BEAT2 : ST_RESP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        // Reset silences the outputs immediately, independent of the clock.
        if (rst) begin
            o_mem_wen   = 8'h00;
            o_rsp_valid = 1'b0;
            o_rsp_rdata = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            r_we    <= 1'b0;
            r_uns   <= 1'b0;
            r_split <= 1'b0;
            r_size  <= 2'd0;
            r_off   <= 3'd0;
            r_addr  <= '0;
            r_wdata <= '0;
            low_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                r_we    <= i_req_we;
                r_uns   <= i_req_unsigned;
                r_split <= split_access(i_req_size, req_off);
                r_size  <= i_req_size;
                r_off   <= req_off;
                r_addr  <= req_addr_aligned;
                r_wdata <= i_req_wdata;
            end
            if (state_q == ST_BEAT2) begin
                low_q <= i_mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_lsu_initiator.sv
module tb_dmem_lsu_initiator;
    import dmem_lsu_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_we = 1'b0;
    logic [1:0]  i_req_size = 2'd0;
    logic        i_req_unsigned = 1'b0;
    logic [63:0] i_req_addr = 64'd0;
    logic [63:0] i_req_wdata = 64'd0;
    logic        o_rsp_valid;
    logic [63:0] o_rsp_rdata;
    logic [63:0] o_mem_addr;
    logic [63:0] o_mem_wdata;
    logic [7:0]  o_mem_wen;
    logic [63:0] i_mem_rdata = 64'd0;
    state_e      o_dbg_state;

    dmem_lsu_initiator #(.DATA_WIDTH(64), .ADDR_WIDTH(64)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_req_valid    (i_req_valid),
        .o_req_ready    (o_req_ready),
        .i_req_we       (i_req_we),
        .i_req_size     (i_req_size),
        .i_req_unsigned (i_req_unsigned),
        .i_req_addr     (i_req_addr),
        .i_req_wdata    (i_req_wdata),
        .o_rsp_valid    (o_rsp_valid),
        .o_rsp_rdata    (o_rsp_rdata),
        .o_mem_addr     (o_mem_addr),
        .o_mem_wdata    (o_mem_wdata),
        .o_mem_wen      (o_mem_wen),
        .i_mem_rdata    (i_mem_rdata),
        .o_dbg_state    (o_dbg_state)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_wait = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- memory environment ----------------
    logic [7:0]  dut_mem[longint unsigned];
    logic [63:0] m_addr = 64'd0;
    logic [7:0]  m_wen = 8'd0;
    logic [63:0] m_wdata = 64'd0;
    logic [63:0] wr_addr_log[$];
    logic [7:0]  wr_wen_log[$];
    logic [7:0]  putc_q[$];
    bit          halt_seen = 1'b0;
    logic [7:0]  halt_wen = 8'd0;

    function automatic logic [7:0] dut_rd(input logic [63:0] a);
        if (dut_mem.exists(a)) return dut_mem[a];
        return 8'h00;
    endfunction

    always @(negedge clk) begin
        m_addr  = o_mem_addr;
        m_wen   = o_mem_wen;
        m_wdata = o_mem_wdata;
    end

    always @(posedge clk) begin
        logic [63:0] rd;
        rd = 64'd0;
        if (m_addr == SIM_CYCLE_ADDR) rd = 64'(cyc);
        else for (int i = 0; i < 8; i++) rd[8*i +: 8] = dut_rd(m_addr + 64'(i));
        i_mem_rdata <= rd;
        if (m_wen != 8'h00) begin
            wr_addr_log.push_back(m_addr);
            wr_wen_log.push_back(m_wen);
            if (m_addr == SIM_PUTCHAR_ADDR) begin
                putc_q.push_back(m_wdata[7:0]);
                $display("putchar: %c", m_wdata[7:0]);
            end else if (m_addr == SIM_HALT_ADDR) begin
                halt_seen = 1'b1;
                halt_wen  = m_wen;
            end else begin
                for (int i = 0; i < 8; i++)
                    if (m_wen[i]) dut_mem[m_addr + 64'(i)] = m_wdata[8*i +: 8];
            end
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] ref_mem[longint unsigned];

    function automatic logic [7:0] ref_rd(input logic [63:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return 8'h00;
    endfunction

    function automatic logic [63:0] model_load(input logic [63:0] a, input logic [1:0] size, input bit uns);
        int n;
        logic [63:0] v;
        n = 1 << size;
        v = 64'd0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_rd(a + 64'(i));
        if (!uns && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
        return v;
    endfunction

    // ---------------- scoreboard ----------------
    logic [63:0] exp_q[$];
    int          exp_cyc_q[$];

    always @(negedge clk) begin
        if (!rst && o_rsp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rsp_unexpected actual=%h required=no_response", o_rsp_rdata);
            end else begin
                logic [63:0] e;
                int ec;
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                check64("rsp_rdata", o_rsp_rdata, e);
                check64("rsp_cycle", 64'(cyc), 64'(ec));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Entered #1 after a posedge; leaves valid high, returns #1 after accept.
    task automatic issue(input bit we, input logic [1:0] size, input bit uns,
                         input logic [63:0] addr, input logic [63:0] wdata);
        bit ok;
        int c;
        int n;
        logic [63:0] e;
        i_req_valid    = 1'b1;
        i_req_we       = we;
        i_req_size     = size;
        i_req_unsigned = uns;
        i_req_addr     = addr;
        i_req_wdata    = wdata;
        ok = 1'b0;
        c = 0;
        last_wait = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (o_req_ready) begin
                ok = 1'b1;
                c = cyc;
                break;
            end
            last_wait++;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL req_accept_timeout actual=not_ready required=ready addr=%h", addr);
            i_req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        n = 1 << size;
        e = 64'd0;
        if (we) begin
            if (addr != SIM_PUTCHAR_ADDR && addr != SIM_HALT_ADDR)
                for (int i = 0; i < n; i++) ref_mem[addr + 64'(i)] = wdata[8*i +: 8];
        end else if (addr == SIM_CYCLE_ADDR) begin
            e = 64'(c);
        end else begin
            e = model_load(addr, size, uns);
        end
        exp_q.push_back(e);
        exp_cyc_q.push_back(c + (((int'(addr[2:0]) + n) > 8) ? 2 : 1));
        #1;
    endtask

    task automatic idle(input int n);
        i_req_valid = 1'b0;
        i_req_we    = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_log(input string name, input logic [63:0] ea, input logic [7:0] ew);
        if (wr_addr_log.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s actual=no_write required=addr %h wen %h", name, ea, ew);
        end else begin
            check64({name, "_addr"}, wr_addr_log.pop_front(), ea);
            check64({name, "_wen"}, 64'(wr_wen_log.pop_front()), 64'(ew));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [63:0] d;
        repeat (3) @(posedge clk);
        #1;
        // A store presented during reset must not reach memory.
        i_req_valid = 1'b1;
        i_req_we    = 1'b1;
        i_req_size  = 2'd3;
        i_req_addr  = 64'h100;
        #1;
        check64("reset_ready", 64'(o_req_ready), 64'd0);
        check64("reset_rsp_valid", 64'(o_rsp_valid), 64'd0);
        check64("reset_wen", 64'(o_mem_wen), 64'd0);
        check64("reset_rdata", o_rsp_rdata, 64'd0);
        check64("reset_state", 64'(o_dbg_state), 64'(ST_IDLE));
        @(posedge clk);
        #1;
        rst = 1'b0;
        i_req_valid = 1'b0;

        // Aligned dword store/load, first accept right after reset.
        wr_addr_log.delete(); wr_wen_log.delete();
        issue(1, 2'd3, 0, 64'h100, 64'h1122334455667788);
        check64("first_accept_wait", 64'(last_wait), 64'd0);
        idle(2);
        check_log("dword_store", 64'h100, 8'hFF);
        issue(0, 2'd3, 0, 64'h100, 64'd0);
        idle(2);

        // Split half store and loads.
        wr_addr_log.delete(); wr_wen_log.delete();
        issue(1, 2'd1, 0, 64'h107, 64'hBEEF);
        idle(2);
        check_log("half_beat0", 64'h100, 8'h80);
        check_log("half_beat1", 64'h108, 8'h01);
        issue(0, 2'd1, 0, 64'h107, 64'd0);
        issue(0, 2'd1, 1, 64'h107, 64'd0);
        idle(3);

        // Byte sign/zero extension.
        issue(1, 2'd0, 0, 64'h203, 64'h80);
        issue(0, 2'd0, 0, 64'h203, 64'd0);
        issue(0, 2'd0, 1, 64'h203, 64'd0);
        idle(2);

        // Back-to-back aligned loads with valid held high.
        for (int i = 0; i < 4; i++) begin
            d = {$urandom, $urandom};
            issue(1, 2'd3, 0, 64'h300 + 64'(8*i), d);
        end
        idle(2);
        issue(0, 2'd3, 0, 64'h300, 64'd0);
        for (int i = 1; i < 4; i++) begin
            issue(0, 2'd3, 0, 64'h300 + 64'(8*i), 64'd0);
            check64("b2b_ready_wait", 64'(last_wait), 64'd0);
        end
        idle(2);

        // Cycle-counter device read.
        issue(0, 2'd3, 1, SIM_CYCLE_ADDR, 64'd0);
        idle(2);

        // Randomized traffic.
        for (int t = 0; t < 200; t++) begin
            logic [1:0] sz;
            sz = 2'($urandom_range(0, 3));
            d  = {$urandom, $urandom};
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                  64'h400 + 64'($urandom_range(0, 16'hF8)), d);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end
        idle(3);

        // putchar device.
        wr_addr_log.delete(); wr_wen_log.delete();
        issue(1, 2'd0, 0, SIM_PUTCHAR_ADDR, 64'h41);
        idle(2);
        check_log("putchar", SIM_PUTCHAR_ADDR, 8'h01);
        if (putc_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL putchar_char actual=none required=41");
        end else begin
            check64("putchar_char", 64'(putc_q.pop_front()), 64'h41);
        end
        check64("putchar_no_mem_write", 64'(dut_rd(SIM_PUTCHAR_ADDR)), 64'd0);

        // Reset during BEAT2 of a misaligned dword store.
        for (int i = 0; i < 16; i++) dut_mem[64'h1F8 + 64'(i)] = 8'(8'hA0 + i);
        i_req_valid    = 1'b1;
        i_req_we       = 1'b1;
        i_req_size     = 2'd3;
        i_req_unsigned = 1'b0;
        i_req_addr     = 64'h1FD;
        i_req_wdata    = 64'h0102030405060708;
        @(negedge clk);
        check64("rst_test_ready", 64'(o_req_ready), 64'd1);
        @(posedge clk);
        #1;
        check64("rst_test_in_beat2", 64'(o_dbg_state), 64'(ST_BEAT2));
        rst = 1'b1;
        i_req_valid = 1'b0;
        i_req_we    = 1'b0;
        #1;
        check64("midrst_ready", 64'(o_req_ready), 64'd0);
        check64("midrst_rsp_valid", 64'(o_rsp_valid), 64'd0);
        check64("midrst_wen", 64'(o_mem_wen), 64'd0);
        check64("midrst_rdata", o_rsp_rdata, 64'd0);
        check64("midrst_state", 64'(o_dbg_state), 64'(ST_IDLE));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check64("midrst_b1FD", 64'(dut_rd(64'h1FD)), 64'h08);
        check64("midrst_b1FE", 64'(dut_rd(64'h1FE)), 64'h07);
        check64("midrst_b1FF", 64'(dut_rd(64'h1FF)), 64'h06);
        for (int i = 0; i < 5; i++)
            check64("midrst_beat1_untouched", 64'(dut_rd(64'h200 + 64'(i))), 64'(8'hA8 + i));
        idle(3);

        // Halt device: dword store of zero.
        issue(1, 2'd3, 0, SIM_HALT_ADDR, 64'd0);
        idle(3);
        check64("halt_seen", 64'(halt_seen), 64'd1);
        check64("halt_wen", 64'(halt_wen), 64'hFF);

        check64("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
